sevenseg_scan: RTL
==================

// Module: sevenseg_scan
// PURPOSE
//  Time-multiplexed 4-digit 7-segment driver that consumes the stopwatch BCD outputs.
//  Inputs are tenmin, onemin, tensec and onesec.
//  Captures a consistent snapshot of the digits once per scan frame.
//  Drives common-anode segment and anode lines (all active-low).
//  Provides a colon decimal point, blink-while-paused and leading-zero blanking.
//  Sits between the stopwatch and the board display pins, all in the clk100MHz domain.
// PARAMETERS
//  REFRESH_DIV   100000  clk100MHz cycles per digit slot (1 ms at 100 MHz); must be > GUARD+1
//  GUARD         4       cycles at slot start with all anodes off (anti-ghosting)
//  BLINK_FRAMES  125     full 4-digit frames per blink half-period while paused
// PORTS
//  clk100MHz  in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  tenminin   in   4  BCD tens of minutes
//  oneminin   in   4  BCD ones of minutes
//  tensecin   in   4  BCD tens of seconds
//  onesecin   in   4  BCD ones of seconds
//  pause      in   1  1 = stopwatch paused; display blinks
//  blank_lz   in   1  1 = blank digit 3 when its snapshot value is 0
//  seg        out  7  {g,f,e,d,c,b,a}, active-low
//  dp         out  1  decimal point, active-low
//  an         out  4  anode enables, active-low; an[0] is the rightmost (onesec) digit
// BEHAVIOUR
//  Reset (rst=0, async): seg=7'h7F, dp=1, an=4'hF.
//   Slot counter=0, digit index=0, snapshot digits=0, sample regs=0, frame counter=0, blink phase=ON.
//  Sampling: inputs registered every cycle into samp; samp registered into samp_d.
//   stable = (samp==samp_d) across all 16 bits.
//  Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0 and increments the digit index.
//   Digit index cycles 0,1,2,3,0.
//  Frame start: cycle where slot counter wraps and index goes 3->0.
//   At frame start, if stable, snapshot <= samp_d; otherwise the snapshot is held (no torn frames).
//  Digit select: index 0=onesec, 1=tensec, 2=onemin, 3=tenmin, taken from the snapshot.
//  Decode (active-low):
//   0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
//   5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
//   Values 10..15 decode to 0111111 (dash, g only).
//  dp: 0 only in slot index 2 (minutes/seconds separator); 1 in all other slots.
//  Guard: while slot counter < GUARD, an=4'hF. Otherwise an = ~(1<<index).
//  Blanking: an=4'hF for the whole slot when index==3, blank_lz=1 and snapshot tenmin==0.
//  Blink: frame counter counts frame starts while pause=1.
//   On reaching BLINK_FRAMES it resets to 0 and toggles the phase.
//   Phase OFF forces an=4'hF.
//   pause=0 forces phase=ON and frame counter=0 immediately.
//  Outputs are registered: seg/dp/an reflect the counter state of the previous cycle (1-cycle latency).
//  Simultaneous events:
//   - Input change at frame start: the unstable check wins; the previous snapshot is kept.
//   - pause falling at frame start: phase=ON wins.
//  Mid-operation reset: every state is cleared at once; the first anode asserts GUARD+1 cycles after rst rises.
// TESTING (REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2)
//  1. Reset: hold rst=0 with any inputs -> seg=7F, dp=1, an=F. Release -> an=E first at cycle 3; cycles 0..2 an=F.
//  2. Scan: digits 1,2,3,4 (tenmin..onesec) held stable, pause=0.
//     Second frame shows an=E seg=0011001, an=D seg=0110000, an=B seg=0100100 dp=0, an=7 seg=1111001.
//  3. Tearing: change onesec 4->5 on the exact frame-start cycle -> next frame still shows 4; following frame shows 5.
//  4. Invalid BCD/blanking: tensec=4'hC -> slot 1 seg=0111111.
//     tenmin=0 with blank_lz=1 -> an stays F in slot 3; with blank_lz=0 -> 1000000 shown.
//  5. Blink: pause=1 -> after 2 frames an=F for 2 full frames, then visible again.
//     Drop pause mid-OFF -> next slot visible.
//  6. Reset mid-slot with index=2 -> outputs off immediately; scan restarts at index 0.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Four-digit common-anode 7-segment scanner for the stopwatch BCD digits.
// Takes a per-frame snapshot of the digits and drives registered, active-low segment and anode lines.
module sevenseg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk100MHz,
  input  logic       rst,
  input  logic [3:0] tenminin,
  input  logic [3:0] oneminin,
  input  logic [3:0] tensecin,
  input  logic [3:0] onesecin,
  input  logic       pause,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [SW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [15:0]   samp;
  logic [15:0]   samp_d;
  logic [15:0]   snap;
  logic [FW-1:0] frame_cnt;
  logic          phase_on;

  logic          slot_wrap;
  logic          frame_start;
  logic          stable;
  logic [3:0]    digit;
  logic          blank_slot;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          dp_next;

  function automatic logic [6:0] decode(input logic [3:0] val);
    case (val)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  always_comb begin
    slot_wrap   = (slot_cnt == SW'(REFRESH_DIV - 1));
    frame_start = slot_wrap && (idx == 2'd3);
    stable      = (samp == samp_d);
    digit       = 4'd0;
    case (idx)
      2'd0: digit = snap[3:0];
      2'd1: digit = snap[7:4];
      2'd2: digit = snap[11:8];
      2'd3: digit = snap[15:12];
      default: digit = 4'd0;
    endcase
    blank_slot = (idx == 2'd3) && blank_lz && (snap[15:12] == 4'd0);
    seg_next   = decode(digit);
    dp_next    = (idx != 2'd2);
    an_next    = 4'hF;
    if (!(slot_cnt < SW'(GUARD)) && !blank_slot && phase_on)
      an_next = ~(4'b0001 << idx);
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      idx      <= 2'd0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  // Two-stage sample; a snapshot is taken only when both stages agree, so a digit
  // rolling over right at frame start never produces a torn frame.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      samp   <= '0;
      samp_d <= '0;
      snap   <= '0;
    end else begin
      samp   <= {tenminin, oneminin, tensecin, onesecin};
      samp_d <= samp;
      if (frame_start && stable)
        snap <= samp_d;
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!pause) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule
